pcie_user_regfile: RTL and testbench

- Parametrised successor of the PCIe BAR0 user register block: PIO read/write port to a generic register map.
- Provides CFG_WORDS byte-enabled RW config registers and a command-request bank with req/ack handshake, replacing level bits that never clear.
- Exposes STAT_CH read-only status channels of 4 words each, plus a pass-through window to an external boot ROM.
- Sits between the PIO engine (rd_addr/wr_en interface) and the Ethernet TX/RX datapath.

---
 rtl/pcie_user_regfile_pkg.sv | 30 +++
 rtl/pcie_user_cmd_bank.sv | 18 +
 rtl/pcie_user_regfile.sv | 154 +++++++++++++++
 tb/tb_pcie_user_regfile.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_user_regfile_pkg.sv
// Shared constants, read-region encoding and byte-lane merge for the PCIe user register file.
package pcie_user_regfile_pkg;

   localparam int CMD_ADDR  = 'h20;
   localparam int ID_ADDR   = 'h21;
   localparam int SNAP_ADDR = 'h22;
   localparam int STAT_BASE = 'h40;

   typedef enum logic [2:0] {
      REGION_CFG,
      REGION_CMD,
      REGION_ID,
      REGION_SNAP,
      REGION_STAT,
      REGION_ROM,
      REGION_NONE
   } region_e;

   // Lane j of the enable covers the byte that starts at bit 31-8*j (big-endian lane order).
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_data,
                                               input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int lane = 0; lane < 4; lane++)
         if (be[lane]) merged[31-8*lane -: 8] = new_data[31-8*lane -: 8];
      return merged;
   endfunction

endpackage

// File: rtl/pcie_user_cmd_bank.sv
// Command-request bank: bits latch on a set pulse and clear on their acknowledge; set beats ack.
module pcie_user_cmd_bank #(
   parameter int CMD_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CMD_BITS-1:0] set,
   input  logic [CMD_BITS-1:0] ack,
   output logic [CMD_BITS-1:0] req
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) req <= '0;
      else     req <= (req & ~ack) | set;
   end

endmodule

// File: rtl/pcie_user_regfile.sv
// PCIe BAR0 user register file: config words, command bank, ID, status channels and boot-ROM window.
// Optional status snapshot shadowing is built when PCIE_USER_REGFILE_STAT_SNAPSHOT_EN is defined.
module pcie_user_regfile
   import pcie_user_regfile_pkg::*;
#(
   parameter int                      ADDR_W    = 11,
   parameter int                      CFG_WORDS = 16,
   parameter logic [CFG_WORDS*32-1:0] CFG_RESET = '0,
   parameter int                      CMD_BITS  = 8,
   parameter int                      STAT_CH   = 3,
   parameter logic [31:0]             VERSION   = 32'h0001_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic [3:0]               rd_be,
   output logic [31:0]              rd_data,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [7:0]               wr_be,
   input  logic [31:0]              wr_data,
   input  logic                     wr_en,
   output logic                     wr_busy,
   output logic [CFG_WORDS*32-1:0]  cfg_q,
   output logic [CMD_BITS-1:0]      cmd_req,
   input  logic [CMD_BITS-1:0]      cmd_ack,
   input  logic [STAT_CH*128-1:0]   stat_in,
   output logic [ADDR_W-3:0]        rom_addr,
   input  logic [31:0]              rom_data
);

   if (ADDR_W < 8 || ADDR_W > 32) begin : g_bad_addr_w
      $error("pcie_user_regfile: ADDR_W must be 8..32");
   end
   if (CFG_WORDS < 1 || CFG_WORDS > 32) begin : g_bad_cfg_words
      $error("pcie_user_regfile: CFG_WORDS must be 1..32");
   end
   if (CMD_BITS < 1 || CMD_BITS > 32) begin : g_bad_cmd_bits
      $error("pcie_user_regfile: CMD_BITS must be 1..32");
   end
   if (STAT_CH < 1 || STAT_CH > 16) begin : g_bad_stat_ch
      $error("pcie_user_regfile: STAT_CH must be 1..16");
   end

   logic [31:0]            cfg [CFG_WORDS];
   logic [CMD_BITS-1:0]    cmd_set;
   logic [STAT_CH*128-1:0] stat_src;
   logic [31:0]            snap_rd;
   region_e                rd_region, region_q;
   logic [31:0]            rd_next, rd_q;
   logic                   unused_ok;

   assign wr_busy   = 1'b0;
   assign rom_addr  = rd_addr[ADDR_W-3:0];
   assign unused_ok = ^{rd_be, wr_be[7:4]};

   // NOTE: the config words are real flops with a defined reset image, so they are reset explicitly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CFG_WORDS; i++) cfg[i] <= CFG_RESET[32*i +: 32];
      end else if (wr_en) begin
         for (int i = 0; i < CFG_WORDS; i++)
            if (wr_addr == ADDR_W'(i)) cfg[i] <= merge_bytes(cfg[i], wr_data, wr_be[3:0]);
      end
   end

   for (genvar g = 0; g < CFG_WORDS; g++) begin : g_cfg_q
      assign cfg_q[32*g +: 32] = cfg[g];
   end

   always_comb begin
      cmd_set = '0;
      if (wr_en && wr_addr == ADDR_W'(CMD_ADDR))
         for (int i = 0; i < CMD_BITS; i++) cmd_set[i] = wr_be[3 - i/8] & wr_data[i];
   end

   pcie_user_cmd_bank #(.CMD_BITS(CMD_BITS)) u_cmd_bank (
      .clk (clk),
      .rst (rst),
      .set (cmd_set),
      .ack (cmd_ack),
      .req (cmd_req)
   );

`ifdef PCIE_USER_REGFILE_STAT_SNAPSHOT_EN
   logic [STAT_CH*128-1:0] stat_shadow;
   logic [31:0]            snap_count;
   logic                   snap_wr;

   assign snap_wr = wr_en && wr_addr == ADDR_W'(SNAP_ADDR) && wr_be[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_shadow <= '0;
         snap_count  <= '0;
      end else if (snap_wr) begin
         stat_shadow <= stat_in;
         snap_count  <= snap_count + 32'd1;
      end
   end

   assign stat_src = stat_shadow;
   assign snap_rd  = snap_count;
`else
   assign stat_src = stat_in;
   assign snap_rd  = '0;
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      rd_region = REGION_NONE;
      rd_next   = '0;
      if (rd_addr[ADDR_W-1 -: 2] == 2'b11) begin
         rd_region = REGION_ROM;
      end else begin
         for (int i = 0; i < CFG_WORDS; i++)
            if (rd_addr == ADDR_W'(i)) begin
               rd_region = REGION_CFG;
               rd_next   = cfg[i];
            end
         if (rd_addr == ADDR_W'(CMD_ADDR)) begin
            rd_region = REGION_CMD;
            rd_next   = 32'(cmd_req);
         end
         if (rd_addr == ADDR_W'(ID_ADDR)) begin
            rd_region = REGION_ID;
            rd_next   = VERSION;
         end
         if (rd_addr == ADDR_W'(SNAP_ADDR)) begin
            rd_region = REGION_SNAP;
            rd_next   = snap_rd;
         end
         for (int c = 0; c < STAT_CH; c++)
            for (int k = 0; k < 4; k++)
               if (rd_addr == ADDR_W'(STAT_BASE + 4*c + k)) begin
                  rd_region = REGION_STAT;
                  rd_next   = stat_src[128*c + 32*k +: 32];
               end
      end
   end

   // ROM data arrives a cycle after rom_addr, so only the region choice is registered for it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q     <= '0;
         region_q <= REGION_NONE;
      end else begin
         rd_q     <= rd_next;
         region_q <= rd_region;
      end
   end

   assign rd_data = (region_q == REGION_ROM) ? rom_data : rd_q;

endmodule

// File: tb/tb_pcie_user_regfile.sv
// Scoreboard bench for pcie_user_regfile; define PCIE_USER_REGFILE_STAT_SNAPSHOT_EN to model snapshots.
module tb_pcie_user_regfile;

   localparam int ADDR_W    = 11;
   localparam int CFG_WORDS = 16;
   localparam int CMD_BITS  = 8;
   localparam int STAT_CH   = 3;
   localparam logic [31:0] VERSION = 32'h0001_0000;
   localparam logic [CFG_WORDS*32-1:0] CFG_RST = {{14{32'h0}}, 32'h0000_0040, 32'h0};

   logic                    clk, rst;
   logic [ADDR_W-1:0]       rd_addr, wr_addr;
   logic [3:0]              rd_be;
   logic [31:0]             rd_data, wr_data;
   logic [7:0]              wr_be;
   logic                    wr_en, wr_busy;
   logic [CFG_WORDS*32-1:0] cfg_q;
   logic [CMD_BITS-1:0]     cmd_req, cmd_ack;
   logic [STAT_CH*128-1:0]  stat_in;
   logic [ADDR_W-3:0]       rom_addr;
   logic [31:0]             rom_data;

   pcie_user_regfile #(
      .ADDR_W(ADDR_W), .CFG_WORDS(CFG_WORDS), .CFG_RESET(CFG_RST),
      .CMD_BITS(CMD_BITS), .STAT_CH(STAT_CH), .VERSION(VERSION)
   ) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_be(rd_be), .rd_data(rd_data),
      .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy),
      .cfg_q(cfg_q), .cmd_req(cmd_req), .cmd_ack(cmd_ack), .stat_in(stat_in),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous boot ROM model: data follows the address by one clock.
   logic [31:0] rom_mem [512];
   initial for (int i = 0; i < 512; i++) rom_mem[i] = 32'hB00F_0000 + 32'(i * 7 + 1);
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int checks, failures;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference model state
   logic [31:0]          cfg_m [CFG_WORDS];
   logic [CMD_BITS-1:0]  cmd_m;
   logic [STAT_CH*128-1:0] shadow_m;
   logic [31:0]          snap_cnt_m;

   task automatic model_reset();
      for (int i = 0; i < CFG_WORDS; i++) cfg_m[i] = CFG_RST[32*i +: 32];
      cmd_m      = '0;
      shadow_m   = '0;
      snap_cnt_m = '0;
   endtask

   function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] ra);
      int a, ch, k;
      logic [STAT_CH*128-1:0] src;
      a = int'(ra);
      if (ra[10:9] == 2'b11) return rom_mem[ra[8:0]];
      if (a < CFG_WORDS) return cfg_m[a];
      if (a == 'h20) return 32'(cmd_m);
      if (a == 'h21) return VERSION;
`ifdef PCIE_USER_REGFILE_STAT_SNAPSHOT_EN
      if (a == 'h22) return snap_cnt_m;
      src = shadow_m;
`else
      if (a == 'h22) return 32'h0;
      src = stat_in;
`endif
      if (a >= 'h40 && a < 'h40 + 4 * STAT_CH) begin
         ch = (a - 'h40) / 4;
         k  = (a - 'h40) % 4;
         return src[128*ch + 32*k +: 32];
      end
      return 32'h0;
   endfunction

   task automatic model_commit(input bit we, input logic [ADDR_W-1:0] wa, input logic [3:0] be,
                               input logic [31:0] wd, input logic [CMD_BITS-1:0] ack);
      int a;
      a = int'(wa);
      if (we && a < CFG_WORDS)
         for (int b = 0; b < 32; b++) if (be[3 - b/8]) cfg_m[a][b] = wd[b];
      for (int i = 0; i < CMD_BITS; i++) begin
         if (we && a == 'h20 && be[3 - i/8] && wd[i]) cmd_m[i] = 1'b1;
         else if (ack[i])                            cmd_m[i] = 1'b0;
      end
`ifdef PCIE_USER_REGFILE_STAT_SNAPSHOT_EN
      if (we && a == 'h22 && be[0]) begin
         shadow_m   = stat_in;
         snap_cnt_m = snap_cnt_m + 1;
      end
`endif
   endtask

   // Scoreboard: driver pushes expected read data, monitor pops when the read data is due.
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       exp;
   } rd_exp_t;
   rd_exp_t sb_q[$];
   rd_exp_t mon_e;
   bit      rd_issue;
   bit      mon_pend;

   always @(posedge clk or posedge rst) begin
      if (rst) mon_pend <= 1'b0;
      else     mon_pend <= rd_issue;
   end

   always @(negedge clk) begin
      if (mon_pend) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'h1, 32'h0);
         end else begin
            mon_e = sb_q.pop_front();
            check($sformatf("rd@%h", mon_e.addr), rd_data, mon_e.exp);
         end
      end
   end

   // One clock of stimulus; called just after a falling edge, returns just after the next one.
   task automatic step(input bit rd, input logic [ADDR_W-1:0] ra, input bit we,
                       input logic [ADDR_W-1:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic [CMD_BITS-1:0] ack);
      rd_exp_t e;
      rd_addr  = ra;
      rd_be    = 4'($urandom);
      rd_issue = rd;
      wr_en    = we;
      wr_addr  = wa;
      wr_be    = {4'($urandom), be};
      wr_data  = wd;
      cmd_ack  = ack;
      if (rd) begin
         e.addr = ra;
         e.exp  = model_read(ra);
         sb_q.push_back(e);
      end
      model_commit(we, wa, be, wd, ack);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("cmd_req", 32'(cmd_req), 32'(cmd_m));
      check("wr_busy", 32'(wr_busy), 32'h0);
      for (int i = 0; i < CFG_WORDS; i++)
         check($sformatf("cfg_q[%0d]", i), cfg_q[32*i +: 32], cfg_m[i]);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] ra);
      step(1'b1, ra, 1'b0, '0, 4'h0, 32'h0, '0);
   endtask

   task automatic wr(input logic [ADDR_W-1:0] wa, input logic [3:0] be, input logic [31:0] wd);
      step(1'b0, '0, 1'b1, wa, be, wd, '0);
   endtask

   function automatic logic [ADDR_W-1:0] pick_addr();
      case ($urandom_range(0, 7))
         0, 1:    return ADDR_W'($urandom_range(0, CFG_WORDS - 1));
         2:       return ADDR_W'($urandom_range('h10, 'h1F));
         3:       return ADDR_W'($urandom_range('h20, 'h23));
         4, 5:    return ADDR_W'($urandom_range('h40, 'h7F));
         6:       return {2'b11, 9'($urandom)};
         default: return ADDR_W'($urandom);
      endcase
   endfunction

   function automatic logic [STAT_CH*128-1:0] rand_stat();
      logic [STAT_CH*128-1:0] s;
      for (int i = 0; i < STAT_CH * 4; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; rd_issue = 1'b0;
      rd_addr = '0; rd_be = '0; wr_addr = '0; wr_be = '0; wr_data = '0; wr_en = 1'b0;
      cmd_ack = '0; stat_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_cmd_req", 32'(cmd_req), 32'h0);
      for (int i = 0; i < CFG_WORDS; i++)
         check($sformatf("rst_cfg[%0d]", i), cfg_q[32*i +: 32], CFG_RST[32*i +: 32]);
      rst = 1'b0;

      // Config reset image, byte lanes, same-cycle read of the written word
      rd(11'h001);
      step(1'b1, 11'h002, 1'b1, 11'h002, 4'b0101, 32'hAABB_CCDD, '0);
      check("cfg_word2", cfg_q[95:64], 32'hAA00_CC00);
      rd(11'h002);
      wr(11'h003, 4'b0000, 32'hFFFF_FFFF);
      rd(11'h003);

      // Command bank: set, read, ack, set-beats-ack, uncovered lane
      wr(11'h020, 4'hF, 32'h0000_0005);
      check("cmd_set5", 32'(cmd_req), 32'h05);
      step(1'b1, 11'h020, 1'b0, '0, 4'h0, 32'h0, 8'h01);
      check("cmd_ack1", 32'(cmd_req), 32'h04);
      step(1'b0, '0, 1'b1, 11'h020, 4'hF, 32'h0000_0004, 8'h04);
      check("cmd_set_wins", 32'(cmd_req), 32'h04);
      step(1'b0, '0, 1'b0, '0, 4'h0, 32'h0, 8'h04);
      check("cmd_ack4", 32'(cmd_req), 32'h00);
      wr(11'h020, 4'b0111, 32'h0000_00FF);
      check("cmd_lane_off", 32'(cmd_req), 32'h00);
      wr(11'h020, 4'hF, 32'h0000_0000);
      rd(11'h020);

      // Status channels, out-of-range channel, ID
      stat_in = rand_stat();
      stat_in[128*2 + 32 +: 32] = 32'h0000_1234;
      rd(11'h049);
      rd(11'h04D);
      rd(11'h021);
      rd(11'h07F);

      // Snapshot (or live reads without the feature)
      wr(11'h022, 4'b0001, 32'h0);
      stat_in = rand_stat();
      rd(11'h049);
      rd(11'h022);
      rd(11'h040);

      // ROM window, then asynchronous reset in the middle of traffic
      wr(11'h020, 4'hF, 32'h0000_00FF);
      rd(11'h600);
      check("rom_addr", 32'(rom_addr), 32'h0);
      rd(11'h605);
      rd_issue = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_rd_data", rd_data, 32'h0);
      check("midrst_cmd_req", 32'(cmd_req), 32'h0);
      for (int i = 0; i < CFG_WORDS; i++)
         check($sformatf("midrst_cfg[%0d]", i), cfg_q[32*i +: 32], CFG_RST[32*i +: 32]);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      rd(11'h001);
      rd(11'h602);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [ADDR_W-1:0] wa;
         bit we;
         if ($urandom_range(0, 9) == 0) stat_in = rand_stat();
         we = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0:       wa = ADDR_W'('h20);
            1:       wa = ADDR_W'('h22);
            default: wa = pick_addr();
         endcase
         step($urandom_range(0, 3) != 0, pick_addr(), we, wa, 4'($urandom), $urandom,
              ($urandom_range(0, 3) == 0) ? CMD_BITS'($urandom) : '0);
      end

      rd_issue = 1'b0;
      wr_en    = 1'b0;
      cmd_ack  = '0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("sb_drain", 32'(sb_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
